bp_me_lce_net_endpoint: RTL



---
 rtl/bp_me_lce_net_endpoint.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/bp_me_lce_net_endpoint.sv
// bp_me_lce_net_endpoint
//   Injection/ejection endpoint for one coherence network on a tile's router
//   P port. The TX side turns one wide LCE/CCE message into a header flit
//   followed by N = ceil(msg_width_p/flit_width_p) payload flits, LSB first.
//   The RX side rebuilds whole messages from incoming header+payload streams.
//   TX and RX run independently.
//
// Header flit layout (LSB first): dest_x | dest_y | len | zeros.
//
// Ports
//   clk_i, reset_i                 clock, synchronous active-high reset
//   tx_msg_i, tx_dest_x_i/_y_i     message and destination to send
//   tx_v_i / tx_ready_o            tx message handshake
//   link_data_o, link_v_o,
//   link_ready_i                   outgoing flit stream to the router
//   link_data_i, link_v_i,
//   link_ready_o                   incoming flit stream from the router
//   rx_msg_o, rx_v_o, rx_yumi_i    reassembled message, valid-yumi handshake
//   rx_len_err_o                   sticky: a header arrived with len != N
module bp_me_lce_net_endpoint #(
  parameter int msg_width_p    = 80,
  parameter int flit_width_p   = 32,
  parameter int x_cord_width_p = 3,
  parameter int y_cord_width_p = 3,
  parameter int len_width_p    = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [msg_width_p-1:0]    tx_msg_i,
  input  logic [x_cord_width_p-1:0] tx_dest_x_i,
  input  logic [y_cord_width_p-1:0] tx_dest_y_i,
  input  logic                      tx_v_i,
  output logic                      tx_ready_o,

  output logic [flit_width_p-1:0]   link_data_o,
  output logic                      link_v_o,
  input  logic                      link_ready_i,

  input  logic [flit_width_p-1:0]   link_data_i,
  input  logic                      link_v_i,
  output logic                      link_ready_o,

  output logic [msg_width_p-1:0]    rx_msg_o,
  output logic                      rx_v_o,
  input  logic                      rx_yumi_i,
  output logic                      rx_len_err_o
);

  localparam int n_flits_lp = (msg_width_p + flit_width_p - 1) / flit_width_p;
  localparam logic [len_width_p-1:0] n_len_lp    = len_width_p'(n_flits_lp);
  localparam logic [len_width_p-1:0] last_idx_lp = len_width_p'(n_flits_lp - 1);
  localparam logic [len_width_p-1:0] one_lp      = len_width_p'(1);
  localparam int len_lsb_lp = x_cord_width_p + y_cord_width_p;

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_BODY} tx_state_e;
  typedef enum logic [1:0] {RX_HDR, RX_BODY, RX_FULL} rx_state_e;

  // ---------------- TX ----------------
  tx_state_e                tx_state_r, tx_state_n;
  logic [len_width_p-1:0]   tx_cnt_r, tx_cnt_n;
  logic                     tx_load;
  logic [msg_width_p-1:0]   tx_msg_r;
  logic [flit_width_p-1:0]  tx_hdr_r;
  logic [flit_width_p-1:0]  tx_flit;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= '0;
    end else begin
      tx_state_r <= tx_state_n;
      tx_cnt_r   <= tx_cnt_n;
    end
  end

  // Message and header are captured once per packet and held until the
  // last payload flit leaves, so link_data_o cannot change under a stall.
  always_ff @(posedge clk_i) begin
    if (tx_load) begin
      tx_msg_r <= tx_msg_i;
      tx_hdr_r <= flit_width_p'({n_len_lp, tx_dest_y_i, tx_dest_x_i});
    end
  end

  // Payload flit cnt is message bits [cnt*flit_width_p +: flit_width_p];
  // bits past the end of the message stay zero.
  always_comb begin
    tx_flit = '0;
    for (int b = 0; b < msg_width_p; b++) begin
      if (int'(tx_cnt_r) == b / flit_width_p) tx_flit[b % flit_width_p] = tx_msg_r[b];
    end
  end

  always_comb begin
    tx_state_n  = tx_state_r;
    tx_cnt_n    = tx_cnt_r;
    tx_load     = 1'b0;
    tx_ready_o  = 1'b0;
    link_v_o    = 1'b0;
    link_data_o = '0;
    unique case (tx_state_r)
      TX_IDLE: begin
        tx_ready_o = ~reset_i;
        if (tx_v_i) begin
          tx_load    = 1'b1;
          tx_state_n = TX_HDR;
        end
      end
      TX_HDR: begin
        link_v_o    = ~reset_i;
        link_data_o = reset_i ? '0 : tx_hdr_r;
        if (link_ready_i) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_BODY;
        end
      end
      TX_BODY: begin
        link_v_o    = ~reset_i;
        link_data_o = reset_i ? '0 : tx_flit;
        if (link_ready_i) begin
          tx_cnt_n = tx_cnt_r + one_lp;
          if (tx_cnt_r == last_idx_lp) tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- RX ----------------
  rx_state_e                rx_state_r, rx_state_n;
  logic [len_width_p-1:0]   rx_cnt_r, rx_cnt_n;
  logic [len_width_p-1:0]   rx_len_r, rx_len_n;
  logic                     rx_drop_r, rx_drop_n;
  logic                     rx_err_r;
  logic                     rx_err_set;
  logic                     rx_wr;
  logic [len_width_p-1:0]   hdr_len;
  logic [msg_width_p-1:0]   rx_msg_r;

  assign hdr_len = link_data_i[len_lsb_lp +: len_width_p];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_state_r <= RX_HDR;
      rx_cnt_r   <= '0;
      rx_len_r   <= '0;
      rx_drop_r  <= 1'b0;
      rx_err_r   <= 1'b0;
    end else begin
      rx_state_r <= rx_state_n;
      rx_cnt_r   <= rx_cnt_n;
      rx_len_r   <= rx_len_n;
      rx_drop_r  <= rx_drop_n;
      if (rx_err_set) rx_err_r <= 1'b1;
    end
  end

  // Payload flit cnt lands in message bits [cnt*flit_width_p +: flit_width_p];
  // flit bits beyond the message width are discarded. Dropped packets never
  // write, so the last delivered message is not disturbed.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < msg_width_p; b++) begin
      if (rx_wr && int'(rx_cnt_r) == b / flit_width_p) rx_msg_r[b] <= link_data_i[b % flit_width_p];
    end
  end

  always_comb begin
    rx_state_n   = rx_state_r;
    rx_cnt_n     = rx_cnt_r;
    rx_len_n     = rx_len_r;
    rx_drop_n    = rx_drop_r;
    rx_err_set   = 1'b0;
    rx_wr        = 1'b0;
    link_ready_o = 1'b0;
    rx_v_o       = 1'b0;
    unique case (rx_state_r)
      RX_HDR: begin
        link_ready_o = ~reset_i;
        if (link_v_i) begin
          rx_len_n = hdr_len;
          rx_cnt_n = '0;
          if (hdr_len == n_len_lp) begin
            rx_drop_n  = 1'b0;
            rx_state_n = RX_BODY;
          end else if (hdr_len == '0) begin
            // Zero-length header carries no payload: flag it and wait for the next header.
            rx_err_set = 1'b1;
          end else begin
            // Wrong length: swallow exactly len flits so framing is kept.
            rx_err_set = 1'b1;
            rx_drop_n  = 1'b1;
            rx_state_n = RX_BODY;
          end
        end
      end
      RX_BODY: begin
        link_ready_o = ~reset_i;
        if (link_v_i) begin
          rx_wr    = ~rx_drop_r;
          rx_cnt_n = rx_cnt_r + one_lp;
          if (rx_cnt_r == rx_len_r - one_lp) rx_state_n = rx_drop_r ? RX_HDR : RX_FULL;
        end
      end
      RX_FULL: begin
        rx_v_o = ~reset_i;
        if (rx_yumi_i) rx_state_n = RX_HDR;
      end
      default: rx_state_n = RX_HDR;
    endcase
  end

  assign rx_msg_o     = reset_i ? '0 : rx_msg_r;
  assign rx_len_err_o = rx_err_r & ~reset_i;

endmodule
